// File: rtl/syn_pipeline_reg.sv
// syn_pipeline_reg: DEPTH-stage valid/payload pipeline register with
// stall, flush and global enable.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  global enable (0 freezes all state)
//   stall, flush        hazard hold / branch squash (flush wins)
//   in_valid, in_data   upstream stage
//   out_valid, out_data last stage, straight from flops
//   stall_cnt, flush_cnt  saturating event counters, present only
//                         when SYN_PIPE_PERF_EN is defined
module syn_pipeline_reg #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEPTH           = 1,
  parameter bit          BUBBLE_ON_STALL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef SYN_PIPE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] nv;
  logic [WIDTH-1:0] d  [DEPTH];
  logic [WIDTH-1:0] nd [DEPTH];

  // A bubble is always valid=0 with an all-zero payload, so a
  // squashed slot can never look like a live control word.
  always_comb begin
    nv = v;
    for (int k = 0; k < DEPTH; k++) begin
      nd[k] = d[k];
    end
    if (en) begin
      if (flush) begin
        nv = '0;
        for (int k = 0; k < DEPTH; k++) begin
          nd[k] = '0;
        end
      end else if (stall) begin
        if (BUBBLE_ON_STALL) begin
          nv[DEPTH-1] = 1'b0;
          nd[DEPTH-1] = '0;
        end
      end else begin
        nv[0] = in_valid;
        nd[0] = in_valid ? in_data : '0;
        for (int k = 1; k < DEPTH; k++) begin
          nv[k] = v[k-1];
          nd[k] = d[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      v <= nv;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= nd[k];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef SYN_PIPE_PERF_EN
  logic stall_ev;
  logic flush_ev;

  assign stall_ev = en && stall && !flush;
  assign flush_ev = en && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_ev && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_syn_pipeline_reg.sv
// tb_syn_pipeline_reg: directed vectors for syn_pipeline_reg.
// Three instances share stimulus; each step checks the relevant one.
module tb_syn_pipeline_reg;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;

  logic        v3, vb, vh;
  logic [31:0] d3, db, dh;

`ifdef SYN_PIPE_PERF_EN
  logic [31:0] sc3, fc3, scb, fcb, sch, fch;
`endif

  int vectors;
  int miscompares;

  syn_pipeline_reg #(.WIDTH(32), .DEPTH(3), .BUBBLE_ON_STALL(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v3), .out_data(d3)
`ifdef SYN_PIPE_PERF_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  syn_pipeline_reg #(.WIDTH(32), .DEPTH(2), .BUBBLE_ON_STALL(1'b1)) u2b (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(vb), .out_data(db)
`ifdef SYN_PIPE_PERF_EN
    , .stall_cnt(scb), .flush_cnt(fcb)
`endif
  );

  syn_pipeline_reg #(.WIDTH(32), .DEPTH(2), .BUBBLE_ON_STALL(1'b0)) u2h (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(vh), .out_data(dh)
`ifdef SYN_PIPE_PERF_EN
    , .stall_cnt(sch), .flush_cnt(fch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic f,
                        input logic iv, input logic [31:0] id);
    stall    = s;
    flush    = f;
    in_valid = iv;
    in_data  = id;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("rst_v3", {31'd0, v3}, 32'd0);
    chk("rst_d3", d3, 32'd0);
    chk("rst_vh", {31'd0, vh}, 32'd0);
`ifdef SYN_PIPE_PERF_EN
    chk("rst_sc", sch, 32'd0);
    chk("rst_fc", fch, 32'd0);
`endif
    rst_n = 1'b1;
    en    = 1'b1;

    // Depth-3 ordering and latency; invalid input becomes zero payload.
    set_in(1'b0, 1'b0, 1'b1, 32'h1);
    tick();
    chk("lat_e1_v", {31'd0, v3}, 32'd0);
    set_in(1'b0, 1'b0, 1'b1, 32'h2);
    tick();
    chk("lat_e2_v", {31'd0, v3}, 32'd0);
    set_in(1'b0, 1'b0, 1'b1, 32'h3);
    tick();
    chk("lat_o1_d", d3, 32'h1);
    chk("lat_o1_v", {31'd0, v3}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 32'hDEAD);
    tick();
    chk("lat_o2_d", d3, 32'h2);
    tick();
    chk("lat_o3_d", d3, 32'h3);
    chk("lat_o3_v", {31'd0, v3}, 32'd1);
    tick();
    chk("lat_bub_d", d3, 32'h0);
    chk("lat_bub_v", {31'd0, v3}, 32'd0);

    // Stall: bubble mode vs hold mode, input not sampled.
    pulse_reset();
    set_in(1'b0, 1'b0, 1'b1, 32'hB);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'hA);
    tick();
    chk("stl_pre_b", db, 32'hB);
    chk("stl_pre_h", dh, 32'hB);
    set_in(1'b1, 1'b0, 1'b1, 32'hC);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl_bub_v", {31'd0, vb}, 32'd0);
      chk("stl_bub_d", db, 32'h0);
      chk("stl_hold_d", dh, 32'hB);
      chk("stl_hold_v", {31'd0, vh}, 32'd1);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("stl_adv_b", db, 32'hA);
    chk("stl_adv_bv", {31'd0, vb}, 32'd1);
    chk("stl_adv_h", dh, 32'hA);
    tick();
    chk("stl_end_b", db, 32'h0);
    chk("stl_end_h", dh, 32'h0);

    // Flush beats stall; both stages squashed.
    pulse_reset();
    set_in(1'b0, 1'b0, 1'b1, 32'h11);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h22);
    tick();
    chk("fl_pre", dh, 32'h11);
    set_in(1'b1, 1'b1, 1'b1, 32'h33);
    tick();
    chk("fl_v", {31'd0, vh}, 32'd0);
    chk("fl_d", dh, 32'h0);
    chk("fl_bv", {31'd0, vb}, 32'd0);
`ifdef SYN_PIPE_PERF_EN
    chk("fl_fc", fch, 32'd1);
    chk("fl_sc", sch, 32'd0);
`endif
    set_in(1'b0, 1'b0, 1'b1, 32'h44);
    tick();
    chk("fl_s0_v", {31'd0, vh}, 32'd0);
    chk("fl_s0_d", dh, 32'h0);
    tick();
    chk("fl_new", dh, 32'h44);

    // en=0 freezes everything whatever the controls do.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(i[0], i[1], ~i[0], 32'h5A5A_0000 + i);
      tick();
      chk("en0_d", dh, 32'h44);
      chk("en0_v", {31'd0, vh}, 32'd1);
`ifdef SYN_PIPE_PERF_EN
      chk("en0_fc", fch, 32'd1);
      chk("en0_sc", sch, 32'd0);
`endif
    end
    en = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("en1_d", dh, 32'h44);

    // Async reset mid-stall.
    set_in(1'b0, 1'b0, 1'b1, 32'h55);
    tick();
    tick();
    chk("ar_pre", dh, 32'h55);
    set_in(1'b1, 1'b0, 1'b1, 32'h55);
    tick();
    chk("ar_stl", dh, 32'h55);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_v", {31'd0, vh}, 32'd0);
    chk("ar_d", dh, 32'h0);
`ifdef SYN_PIPE_PERF_EN
    chk("ar_sc", sch, 32'd0);
    chk("ar_fc", fch, 32'd0);
`endif
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 32'h66);
    tick();
    chk("ar_e1_v", {31'd0, vh}, 32'd0);
    tick();
    chk("ar_e2_d", dh, 32'h66);

`ifdef SYN_PIPE_PERF_EN
    // Counter saturation.
    force u2h.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release u2h.stall_cnt;
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_sc", sch, 32'hFFFF_FFFF);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
